// File: rtl/hyperram_pkg.sv
// Shared HyperBus definitions: target FSM states, command/address field positions
// and the identification/configuration defaults used by both target and controller.
package hyperram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CA,
      LAT,
      WRITE,
      READ,
      REGW,
      DESEL
   } state_e;

   localparam int CA_BITS      = 48;
   localparam int CA_BYTES     = 6;
   localparam int CA_RW_BIT    = 47;
   localparam int CA_AS_BIT    = 46;
   localparam int CA_BURST_BIT = 45;
   localparam int CA_ROW_HI    = 44;
   localparam int CA_ROW_LO    = 16;
   localparam int CA_COL_HI    = 2;
   localparam int CA_COL_LO    = 0;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 8;

   localparam logic [15:0] ID0_DEFAULT = 16'h0C81;
   localparam logic [15:0] CFG_RESET   = 16'h8F1F;

endpackage

// File: rtl/hyperram_target_mem.sv
// Byte-wide storage for the HyperRAM target: one synchronous write port and one
// asynchronous read port. Contents are deliberately left out of reset.
module hyperram_target_mem
   import hyperram_pkg::*;
#(
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [ADDR_BITS-1:0] waddr_i,
   input  logic [DATA_W-1:0]    wdata_i,
   input  logic [ADDR_BITS-1:0] raddr_i,
   output logic [DATA_W-1:0]    rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hyperram_target.sv
// SDR HyperBus memory-side target: collects the 6-byte command/address, waits a
// fixed latency, then streams a linear wrapping burst to or from the byte array.
module hyperram_target
   import hyperram_pkg::*;
#(
   parameter int          LATENCY   = 6,
   parameter int          ADDR_BITS = 8,
   parameter logic [15:0] ID0       = ID0_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs_n,
   input  logic [7:0]  dq_in,
   output logic [7:0]  dq_out,
   output logic        dq_oe,
   input  logic        rwds_in,
   output logic        rwds_out,
   output logic        rwds_oe,
   output logic [15:0] cfg_reg
);

   state_e                 state_q, state_d;
   logic [CA_BITS-1:0]     ca_q, ca_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [15:0]            cfgReg_q, cfgReg_d;
   logic                   armed_q, armed_d;
   logic                   memWe;
   logic [DATA_W-1:0]      memRdata;
   logic                   unusedCaBits;

   // Burst type and the top CA bits only matter while shifting; linear bursts ignore them.
   assign unusedCaBits = ^ca_q[CA_BURST_BIT:40];

   hyperram_target_mem #(
      .ADDR_BITS (ADDR_BITS)
   ) u_mem (
      .clk     (clk),
      .we_i    (memWe),
      .waddr_i (addr_q),
      .wdata_i (dq_in),
      .raddr_i (addr_q),
      .rdata_o (memRdata)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         ca_q     <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         cfgReg_q <= CFG_RESET;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ca_q     <= ca_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         cfgReg_q <= cfgReg_d;
         armed_q  <= armed_d;
      end
   end

   // armed_q blocks a transaction from starting until cs_n has been seen high after reset.
   always_comb begin
      state_d  = state_q;
      ca_d     = ca_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      cfgReg_d = cfgReg_q;
      armed_d  = armed_q | cs_n;
      memWe    = 1'b0;
      dq_out   = '0;
      dq_oe    = 1'b0;
      rwds_out = 1'b0;
      rwds_oe  = 1'b0;

      case (state_q)
         CA: rwds_oe = 1'b1;
         READ: begin
            dq_oe    = 1'b1;
            rwds_oe  = 1'b1;
            rwds_out = ~addr_q[0];
            if (ca_q[CA_AS_BIT]) begin
               dq_out = addr_q[0] ? ID0[7:0] : ID0[15:8];
            end else begin
               dq_out = memRdata;
            end
         end
         default: ;
      endcase

      if (cs_n) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (armed_q) begin
                  ca_d    = {ca_q[CA_BITS-9:0], dq_in};
                  cnt_d   = CNT_W'(1);
                  state_d = CA;
               end
            end
            CA: begin
               ca_d = {ca_q[CA_BITS-9:0], dq_in};
               if (cnt_q == CNT_W'(CA_BYTES - 1)) begin
                  cnt_d   = '0;
                  addr_d  = ADDR_BITS'({ca_d[CA_ROW_HI:CA_ROW_LO], ca_d[CA_COL_HI:CA_COL_LO], 1'b0});
                  state_d = (!ca_d[CA_RW_BIT] && ca_d[CA_AS_BIT]) ? REGW : LAT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            LAT: begin
               if (cnt_q == CNT_W'(LATENCY - 1)) begin
                  cnt_d   = '0;
                  state_d = ca_q[CA_RW_BIT] ? READ : WRITE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WRITE: begin
               memWe  = ~rwds_in;
               addr_d = addr_q + ADDR_BITS'(1);
            end
            READ: begin
               addr_d = addr_q + ADDR_BITS'(1);
            end
            REGW: begin
               if (cnt_q == '0) begin
                  cfgReg_d[15:8] = dq_in;
                  cnt_d          = CNT_W'(1);
               end else begin
                  cfgReg_d[7:0] = dq_in;
                  cnt_d         = '0;
                  state_d       = DESEL;
               end
            end
            DESEL: ;
            default: state_d = IDLE;
         endcase
      end
   end

   assign cfg_reg = cfgReg_q;

endmodule

// File: doc/hyperram_target.md
HYPERRAM_TARGET -- requirements
Module: hyperram_target

Interface
REQ-001 SHALL have parameter LATENCY, default 6, clk cycles from the last CA byte to the first data byte in memory space.
REQ-002 SHALL have parameter ADDR_BITS, default 8, byte-address width of the internal array (2^ADDR_BITS bytes).
REQ-003 SHALL have parameter ID0, default 16'h0C81, value returned for register-space reads.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 cs_n  input  1  chip select, active-low; frames one transaction.
REQ-007 dq_in  input  8  byte from the initiator, sampled each clk while cs_n low.
REQ-008 dq_out  output  8  read data byte.
REQ-009 dq_oe  output  1  high while dq_out is valid.
REQ-010 rwds_in  input  1  write byte mask, high = byte masked.
REQ-011 rwds_out  output  1  read strobe / latency indicator.
REQ-012 rwds_oe  output  1  high while rwds_out is driven.
REQ-013 cfg_reg  output  16  last value written to register space.

Function
REQ-014 SHALL implement an SDR HyperBus target: one dq byte per clk while cs_n low, memory side only.
REQ-015 States: IDLE, CA, LAT, WRITE, READ, REGW, DESEL.
REQ-016 IDLE->CA on the first clk with cs_n low; that byte is CA[47:40].
REQ-017 CA: six bytes MSB first into ca[47:0]; 6th byte -> LAT, or -> REGW if ca[47]=0 and ca[46]=1.
REQ-018 Decode: ca[47]=1 read / 0 write; ca[46]=1 register space; word address = {ca[44:16], ca[2:0]}; byte address = word address*2, truncated to ADDR_BITS.
REQ-019 During CA: rwds_oe=1, rwds_out=0 (fixed 1x latency).
REQ-020 LAT: count LATENCY clk with dq_oe=0, rwds_oe=0; then -> READ if read, else WRITE.
REQ-021 WRITE: each clk store dq_in at the current byte address unless rwds_in=1; then increment the address.
REQ-022 READ: dq_out = array[address], dq_oe=1, rwds_oe=1, rwds_out = ~address[0]; increment each clk.
REQ-023 Register read: READ returns ID0[15:8] then ID0[7:0], repeating.
REQ-024 REGW: first byte -> cfg_reg[15:8], second -> cfg_reg[7:0], then -> DESEL; zero latency.
REQ-025 Address SHALL wrap modulo 2^ADDR_BITS; linear burst only, ca[45] ignored.
REQ-026 cs_n high in any state SHALL -> IDLE next clk with dq_oe=0 and rwds_oe=0; bytes already written stay committed.
REQ-027 DESEL: ignore dq_in until cs_n high.
REQ-028 cs_n high and low on consecutive clks SHALL start a new CA cleanly.
REQ-029 Read latency: first dq_out valid LATENCY+1 clk after the 6th CA byte is sampled.

Reset
REQ-030 rst=0 at a clk edge SHALL force IDLE, dq_oe=0, rwds_oe=0, dq_out=0, rwds_out=0, cfg_reg=16'h8F1F, ca=0, counters=0; array contents are not reset.
REQ-031 Reset mid-burst SHALL abort the burst; the next transaction requires cs_n to go high then low.

Structure
REQ-032 Package hyperram_pkg SHALL hold the state enum, CA bit positions, the default ID0 and the cfg_reg reset value, shared with the hyperram controller.
REQ-033 The byte array SHALL be the sub-module hyperram_target_mem: one write port and one asynchronous read port.

Verification
REQ-034 Write CA 20 00 00 00 00 02, after LATENCY write AA 55 with rwds_in=0 -> array[4]=AA, array[5]=55.
REQ-035 Read CA A0 00 00 00 00 02 -> dq_out AA then 55 on clk 7 and 8 after CA; rwds_out 1 then 0.
REQ-036 Write with rwds_in=1 on the 2nd byte -> that byte is unchanged.
REQ-037 Register write 60 00 01 00 00 00 + 8F 1E -> cfg_reg=16'h8F1E; register read -> 0C 81 0C.
REQ-038 Read at byte address FE, 4 bytes -> addresses FE FF 00 01 returned (wrap).
REQ-039 cs_n high on the 3rd CA byte, or rst=0 mid-read -> dq_oe=0 next clk; a following full write succeeds.
